min_queue_sched: RTL and testbench
==================================

Name: min_queue_sched

Overview:
- Scheduler/controller for the min-queue sorted record RAM.
- Drains records from the input FIFO and insertion-sorts them into a simple-dual-port RAM, with the minimum key at address count-1.
- Serves pops from a registered top-of-queue copy.
- Arbitrates the single RAM between insertion and top-reload, and generates min_valid, empty and full.

Parameters:
Q_DEPTH, 1024, RAM capacity in records
PTR_WD, 10, RAM address width; 2**PTR_WD == Q_DEPTH
REC_WD, 48, record width
KEY_WD, 16, key width; key = record[REC_WD-1 -: KEY_WD], unsigned

Ports:
clk  in  1  single clock
rst_b  in  1  reset; synchronous, active-high
pop  in  1  pop request; accepted only when min_valid=1
pop_record  out  REC_WD  registered min record, valid when min_valid=1
min_valid  out  1  pop_record is the current minimum and a pop is accepted this cycle
empty  out  1  count==0
full  out  1  count==Q_DEPTH
count  out  PTR_WD+1  records held in the RAM
fifo_empty  in  1  input FIFO has no record
fifo_rd  out  1  one-cycle FIFO pop; fifo_data is valid the following cycle
fifo_data  in  REC_WD  FIFO head data
ram_we  out  1  RAM write enable
ram_waddr  out  PTR_WD  write address
ram_wdata  out  REC_WD  write data
ram_re  out  1  RAM read enable
ram_raddr  out  PTR_WD  read address
ram_rdata  in  REC_WD  read data, 1-cycle latency after ram_re
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, count=0, pop_record=0, min_valid=0, empty=1, full=0, fifo_rd=0, ram_we=0, ram_re=0, busy=0. RAM contents are don't-care.
- Reset mid-operation aborts any insertion or reload; a partially shifted RAM is harmless because count=0.
- RAM ordering: address 0 holds the largest key, address count-1 the smallest.
  - Equal keys keep arrival order; the older record sits at the higher address and pops first.
- min_valid = (state==IDLE) && count>0, combinational from registered state/count. Low in every other state.
- States: IDLE, FETCH, CMP, INS, LOAD, TOPCAP.
- IDLE:
  - Pop priority: pop && min_valid -> count-=1.
    - If the old count==1 -> stay IDLE (empty=1).
    - Otherwise -> LOAD.
  - Else if !fifo_empty && !full -> fifo_rd=1 for one cycle -> FETCH.
  - pop while min_valid=0 is ignored, no side effect.
  - Never issue fifo_rd while full.
- FETCH:
  - new_rec <= fifo_data; ptr <= count-1.
  - count==0 -> ins_addr=0 -> INS.
  - Else ram_re=1, ram_raddr=count-1 -> CMP.
- CMP (ram_rdata = RAM[ptr]):
  - key(rdata) <= key(new_rec): write rdata to ptr+1 (shift up).
    - ptr==0 -> ins_addr=0 -> INS.
    - Else ptr-=1, ram_re=1 at ptr-1, stay in CMP. One entry is shifted per cycle.
  - key(rdata) > key(new_rec): write new_rec to ptr+1 -> completion.
- INS: write new_rec at ins_addr -> completion.
- Completion (same cycle as the final write):
  - count+=1.
  - If the write address equals the old count (new record is the new minimum), pop_record <= new_rec. Otherwise pop_record is unchanged, because the old top was shifted intact.
  - -> IDLE.
- LOAD: ram_re=1, ram_raddr=count-1 (post-decrement) -> TOPCAP.
- TOPCAP: pop_record <= ram_rdata -> IDLE.
- Latency, with fifo_rd at cycle T:
  - Empty queue: min_valid high at T+3.
  - New minimum into a non-empty queue: min_valid high at T+3.
  - Record whose key is >= every stored key, with N entries stored: min_valid high at T+3+N (worst case).
  - Pop accepted at T: min_valid low at T+1 and T+2, high at T+3.
- Ports: ram_we and ram_re are never asserted in the same state for the same address. Writes land at the addresses stated above only.
- Widths: count is PTR_WD+1 bits. ptr+1 never exceeds Q_DEPTH-1, because insertion only starts when count<Q_DEPTH.

Test Plan:
- Reset, then push key 0x0005 into an empty queue -> fifo_rd at T; RAM[0] written at T+2; min_valid=1 and pop_record key=0x0005 at T+3; count=1; empty=0.
- Push keys 0x0030, 0x0010, 0x0020 in order -> final RAM keys [0x0030, 0x0020, 0x0010]; pop_record key=0x0010. The 0x0020 insert takes one shift cycle.
- Equal keys: push recA(key 7) then recB(key 7) -> first pop returns recA, second pop returns recB, then empty=1 and min_valid=0.
- Fill: push Q_DEPTH records -> full=1; further fifo_empty=0 produces no fifo_rd. One pop -> full=0 and the next fifo_rd is issued from IDLE.
- Pop and pending FIFO data in the same IDLE cycle -> the pop is served first (no fifo_rd that cycle); fifo_rd follows the TOPCAP-to-IDLE return; pop_record shows the next minimum at T+3.
- Assert rst_b during CMP with count=5 -> next cycle count=0, min_valid=0, empty=1, no RAM write; a subsequent push behaves as in the empty-queue case.

Source files
------------

// File: rtl/min_queue_sched.sv
// Min-queue controller: insertion-sorts FIFO records into a simple-dual-port RAM
// (minimum at address count-1) and serves pops from a registered top-of-queue copy.
module min_queue_sched #(
  parameter int Q_DEPTH = 1024,
  parameter int PTR_WD  = 10,
  parameter int REC_WD  = 48,
  parameter int KEY_WD  = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              pop,
  output logic [REC_WD-1:0] pop_record,
  output logic              min_valid,
  output logic              empty,
  output logic              full,
  output logic [PTR_WD:0]   count,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [REC_WD-1:0] fifo_data,
  output logic              ram_we,
  output logic [PTR_WD-1:0] ram_waddr,
  output logic [REC_WD-1:0] ram_wdata,
  output logic              ram_re,
  output logic [PTR_WD-1:0] ram_raddr,
  input  logic [REC_WD-1:0] ram_rdata,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, FETCH, CMP, INS, LOAD, TOPCAP} state_t;

  localparam logic [PTR_WD:0]   FULL_CNT = (PTR_WD+1)'(Q_DEPTH);
  localparam logic [PTR_WD:0]   ONE_C    = (PTR_WD+1)'(1);
  localparam logic [PTR_WD-1:0] ONE_P    = PTR_WD'(1);

  state_t            state;
  logic [PTR_WD-1:0] ptr;
  logic [REC_WD-1:0] new_rec;
  logic [PTR_WD-1:0] top_addr;
  logic              cnt_zero, pop_acc, shift;

  // Low bits of count-1 wrap correctly even when count==Q_DEPTH.
  assign top_addr  = count[PTR_WD-1:0] - ONE_P;
  assign cnt_zero  = (count == '0);
  assign shift     = ram_rdata[REC_WD-1 -: KEY_WD] <= new_rec[REC_WD-1 -: KEY_WD];
  assign min_valid = (state == IDLE) && !cnt_zero;
  assign pop_acc   = pop && min_valid;
  assign fifo_rd   = (state == IDLE) && !pop_acc && !fifo_empty && !full;
  assign empty     = cnt_zero;
  assign full      = (count == FULL_CNT);
  assign busy      = (state != IDLE);

  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = top_addr;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = new_rec;
    case (state)
      FETCH: ram_re = !cnt_zero;
      CMP: begin
        ram_we    = 1'b1;
        ram_waddr = ptr + ONE_P;
        if (shift) begin
          ram_wdata = ram_rdata;
          ram_re    = (ptr != '0);
          ram_raddr = ptr - ONE_P;
        end
      end
      INS:     ram_we = 1'b1;
      LOAD:    ram_re = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state      <= IDLE;
      count      <= '0;
      pop_record <= '0;
      new_rec    <= '0;
      ptr        <= '0;
    end else begin
      case (state)
        IDLE:
          if (pop_acc) begin
            count <= count - ONE_C;
            state <= (count == ONE_C) ? IDLE : LOAD;
          end else if (fifo_rd) begin
            state <= FETCH;
          end
        FETCH: begin
          new_rec <= fifo_data;
          ptr     <= top_addr;
          state   <= cnt_zero ? INS : CMP;
        end
        CMP:
          if (shift) begin
            if (ptr == '0) state <= INS;
            else           ptr   <= ptr - ONE_P;
          end else begin
            count <= count + ONE_C;
            // Only a write just past the old minimum changes the top; otherwise it was shifted intact.
            if (({1'b0, ptr} + ONE_C) == count) pop_record <= new_rec;
            state <= IDLE;
          end
        INS: begin
          count <= count + ONE_C;
          if (cnt_zero) pop_record <= new_rec;
          state <= IDLE;
        end
        LOAD:   state <= TOPCAP;
        TOPCAP: begin
          pop_record <= ram_rdata;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_min_queue_sched.sv
// Bench for min_queue_sched: FIFO/RAM environment models plus a priority-queue reference.
module tb_min_queue_sched;
  localparam int QD = 16, PW = 4, RW = 48, KW = 16;
  typedef logic [RW-1:0] rec_t;

  logic clk = 1'b0, rst_b = 1'b1, pop = 1'b0;
  rec_t pop_record, ram_wdata, ram_rdata, fifo_data = '0;
  logic min_valid, empty, full, fifo_empty, fifo_rd, ram_we, ram_re, busy;
  logic [PW:0] count;
  logic [PW-1:0] ram_waddr, ram_raddr;
  int errors = 0, checks = 0;

  rec_t mem [QD];
  rec_t fq[$];
  rec_t mq[$];
  logic fq_empty_r = 1'b1, fifo_block = 1'b0;

  min_queue_sched #(.Q_DEPTH(QD), .PTR_WD(PW), .REC_WD(RW), .KEY_WD(KW)) dut (
    .clk(clk), .rst_b(rst_b), .pop(pop), .pop_record(pop_record), .min_valid(min_valid),
    .empty(empty), .full(full), .count(count), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_data(fifo_data), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .busy(busy));

  always #5 clk = ~clk;

  assign fifo_empty = fq_empty_r | fifo_block;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (fifo_rd && fq.size() > 0) fifo_data <= fq.pop_front();
    fq_empty_r <= (fq.size() == 0);
  end

  always @(negedge clk) if (!rst_b) begin
    if (fifo_rd) begin
      checks++;
      if (full) begin errors++; $display("FAIL rd_while_full got fifo_rd=1 full=1 want no read"); end
    end
    if (ram_we && ram_re) begin
      checks++;
      if (ram_waddr == ram_raddr) begin errors++; $display("FAIL port_clash got waddr=raddr=%0d want distinct", ram_waddr); end
    end
  end

  function automatic logic [KW-1:0] key(input rec_t r);
    return r[RW-1 -: KW];
  endfunction
  function automatic rec_t mk(input logic [KW-1:0] k);
    return {k, 32'($urandom)};
  endfunction
  // Entries a new record must pass: stored keys <= its key (older equal keys stay ahead).
  function automatic int n_le(input rec_t r);
    int n = 0;
    foreach (mq[i]) if (key(mq[i]) <= key(r)) n++;
    return n;
  endfunction
  // Oldest record holding the smallest key.
  function automatic int min_idx();
    int m = 0;
    foreach (mq[i]) if (key(mq[i]) < key(mq[m])) m = i;
    return m;
  endfunction

  task automatic do_reset();
    rst_b = 1'b1; pop = 1'b0; fifo_block = 1'b0;
    fq.delete(); mq.delete();
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic insert(input rec_t r, output int lat);
    int k = 0;
    lat = -1;
    fq.push_back(r);
    do begin @(negedge clk); k++; end while (!fifo_rd && k < 20);
    if (!fifo_rd) return;
    k = 0;
    do begin @(negedge clk); k++; end while (!min_valid && k < QD + 10);
    if (min_valid) lat = k;
  endtask

  task automatic pop_one(output rec_t r, output int lat, output int rd_at, output rec_t top);
    int k = 0;
    while (!min_valid && k < 50) begin @(negedge clk); k++; end
    r = pop_record; pop = 1'b1; fifo_block = 1'b0;
    #1 rd_at = fifo_rd ? 0 : -1;
    lat = -1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); pop = 1'b0;
      if (min_valid && lat < 0) lat = i;
      if (fifo_rd && rd_at < 0) rd_at = i;
    end
    top = pop_record;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({min_valid, empty, full, fifo_rd, ram_we, ram_re, busy} !== 7'b0100000) begin
      errors++; $display("FAIL reset_flags got %b want 0100000", {min_valid, empty, full, fifo_rd, ram_we, ram_re, busy});
    end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (pop_record !== '0) begin errors++; $display("FAIL reset_top got %h want 0", pop_record); end
  endtask

  task automatic test_empty_push();
    rec_t r, r2, top;
    int k, lat, rd;
    r = mk(16'h0005); k = 0;
    fq.push_back(r);
    do begin @(negedge clk); k++; end while (!fifo_rd && k < 20);
    checks++;
    if (!fifo_rd) begin errors++; $display("FAIL empty_rd got no fifo_rd want fifo_rd"); end
    @(negedge clk);
    checks++;
    if (min_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL empty_T1 got mv=%b busy=%b want 0 1", min_valid, busy); end
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_waddr !== '0 || ram_wdata !== r) begin
      errors++; $display("FAIL empty_T2_write got we=%b a=%0d d=%h want 1 0 %h", ram_we, ram_waddr, ram_wdata, r);
    end
    @(negedge clk);
    checks++;
    if (min_valid !== 1'b1 || pop_record !== r || count !== 1 || empty !== 1'b0) begin
      errors++; $display("FAIL empty_T3 got mv=%b rec=%h cnt=%0d e=%b want 1 %h 1 0", min_valid, pop_record, count, empty, r);
    end
    pop_one(r2, lat, rd, top);
    checks++;
    if (r2 !== r || lat !== -1 || empty !== 1'b1) begin
      errors++; $display("FAIL empty_pop got rec=%h lat=%0d e=%b want %h -1 1", r2, lat, empty, r);
    end
  endtask

  task automatic test_order();
    logic [KW-1:0] ks [3];
    rec_t r, exp, top;
    int lat, exp_lat, rd, m;
    ks = '{16'h0030, 16'h0010, 16'h0020};
    do_reset();
    foreach (ks[i]) begin
      r = mk(ks[i]); exp_lat = 3 + n_le(r);
      insert(r, lat); mq.push_back(r);
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL order_lat%0d got %0d want %0d", i, lat, exp_lat); end
    end
    checks++;
    if ({key(mem[0]), key(mem[1]), key(mem[2])} !== 48'h0030_0020_0010) begin
      errors++; $display("FAIL order_ram got %h %h %h want 0030 0020 0010", key(mem[0]), key(mem[1]), key(mem[2]));
    end
    checks++;
    if (key(pop_record) !== 16'h0010) begin errors++; $display("FAIL order_top got %h want 0010", key(pop_record)); end
    repeat (3) begin
      m = min_idx(); exp = mq[m]; mq.delete(m);
      pop_one(r, lat, rd, top);
      checks++;
      if (r !== exp) begin errors++; $display("FAIL order_pop got %h want %h", r, exp); end
    end
    checks++;
    if (empty !== 1'b1 || min_valid !== 1'b0) begin errors++; $display("FAIL order_empty got e=%b mv=%b want 1 0", empty, min_valid); end
  endtask

  task automatic test_equal();
    rec_t a, b, r, top;
    int lat, rd;
    do_reset();
    a = mk(16'h0007); b = {16'h0007, ~a[31:0]};
    insert(a, lat);
    insert(b, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL equal_lat got %0d want 4", lat); end
    pop_one(r, lat, rd, top);
    checks++;
    if (r !== a || lat !== 3) begin errors++; $display("FAIL equal_first got %h lat=%0d want %h 3", r, lat, a); end
    pop_one(r, lat, rd, top);
    checks++;
    if (r !== b || empty !== 1'b1 || min_valid !== 1'b0) begin
      errors++; $display("FAIL equal_second got %h e=%b mv=%b want %h 1 0", r, empty, min_valid, b);
    end
  endtask

  task automatic test_fill();
    rec_t r, x, exp, top;
    int lat, rd, m, k;
    logic seen;
    do_reset();
    for (int i = 0; i < QD; i++) begin
      r = mk(16'($urandom_range(0, 255))); insert(r, lat); mq.push_back(r);
    end
    checks++;
    if (count !== (PW+1)'(QD) || full !== 1'b1) begin errors++; $display("FAIL fill_full got cnt=%0d full=%b want %0d 1", count, full, QD); end
    x = mk(16'($urandom_range(0, 255)));
    fq.push_back(x);
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (fifo_rd) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL fill_no_rd got fifo_rd=1 want 0"); end
    m = min_idx(); exp = mq[m]; mq.delete(m);
    pop_one(r, lat, rd, top);
    checks++;
    if (r !== exp) begin errors++; $display("FAIL fill_pop got %h want %h", r, exp); end
    checks++;
    if (rd !== 3) begin errors++; $display("FAIL fill_rd_after_pop got offset %0d want 3", rd); end
    checks++;
    if (full !== 1'b0 || count !== (PW+1)'(QD-1)) begin errors++; $display("FAIL fill_unfull got full=%b cnt=%0d want 0 %0d", full, count, QD-1); end
    k = 0;
    do begin @(negedge clk); k++; end while (!min_valid && k < QD + 10);
    mq.push_back(x);
    checks++;
    if (count !== (PW+1)'(QD) || pop_record !== mq[min_idx()]) begin
      errors++; $display("FAIL fill_refill got cnt=%0d top=%h want %0d %h", count, pop_record, QD, mq[min_idx()]);
    end
    for (int i = 0; i < QD; i++) begin
      m = min_idx(); exp = mq[m]; mq.delete(m);
      pop_one(r, lat, rd, top);
      checks++;
      if (r !== exp) begin errors++; $display("FAIL drain_pop%0d got %h want %h", i, r, exp); end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
  endtask

  task automatic test_pop_priority();
    rec_t r, x, exp, nxt, top;
    int lat, rd, m, k;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      r = mk(16'(i * 256)); insert(r, lat); mq.push_back(r);
    end
    fifo_block = 1'b1;
    x = mk(16'h0050);
    fq.push_back(x);
    repeat (3) @(negedge clk);
    m = min_idx(); exp = mq[m]; mq.delete(m); nxt = mq[min_idx()];
    pop_one(r, lat, rd, top);
    checks++;
    if (r !== exp || lat !== 3) begin errors++; $display("FAIL prio_pop got %h lat=%0d want %h 3", r, lat, exp); end
    checks++;
    if (rd !== 3) begin errors++; $display("FAIL prio_rd got offset %0d want 3", rd); end
    checks++;
    if (top !== nxt) begin errors++; $display("FAIL prio_top got %h want %h", top, nxt); end
    k = 0;
    do begin @(negedge clk); k++; end while (!min_valid && k < QD + 10);
    mq.push_back(x);
    checks++;
    if (pop_record !== x || count !== 3) begin errors++; $display("FAIL prio_ins got %h cnt=%0d want %h 3", pop_record, count, x); end
  endtask

  task automatic test_reset_mid();
    rec_t r;
    int lat, k;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      r = mk(16'(i)); insert(r, lat); mq.push_back(r);
    end
    checks++;
    if (count !== 5) begin errors++; $display("FAIL mid_count got %0d want 5", count); end
    fq.push_back(mk(16'h00ff));
    k = 0;
    do begin @(negedge clk); k++; end while (!fifo_rd && k < 20);
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL mid_cmp got busy=%b we=%b want 1 1", busy, ram_we); end
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if ({count, min_valid, empty, ram_we, busy} !== {5'd0, 4'b0100}) begin
      errors++; $display("FAIL mid_reset got cnt=%0d mv=%b e=%b we=%b busy=%b want 0 0 1 0 0", count, min_valid, empty, ram_we, busy);
    end
    rst_b = 1'b0; mq.delete();
    r = mk(16'h0005);
    insert(r, lat); mq.push_back(r);
    checks++;
    if (lat !== 3 || pop_record !== r || count !== 1 || empty !== 1'b0) begin
      errors++; $display("FAIL mid_repush got lat=%0d rec=%h cnt=%0d want 3 %h 1", lat, pop_record, count, r);
    end
  endtask

  task automatic test_random();
    rec_t r, exp, top;
    int lat, exp_lat, rd, m, exp_pl;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      if (mq.size() == 0 || (mq.size() < QD && $urandom_range(0, 2) != 0)) begin
        r = mk(16'($urandom_range(0, 7))); exp_lat = 3 + n_le(r);
        insert(r, lat); mq.push_back(r);
        checks++;
        if (lat !== exp_lat || pop_record !== mq[min_idx()]) begin
          errors++; $display("FAIL rand_ins%0d got lat=%0d top=%h want %0d %h", n, lat, pop_record, exp_lat, mq[min_idx()]);
        end
      end else begin
        m = min_idx(); exp = mq[m]; mq.delete(m);
        exp_pl = (mq.size() > 0) ? 3 : -1;
        pop_one(r, lat, rd, top);
        checks++;
        if (r !== exp || lat !== exp_pl) begin
          errors++; $display("FAIL rand_pop%0d got %h lat=%0d want %h %0d", n, r, lat, exp, exp_pl);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_push();
    test_order();
    test_equal();
    test_fill();
    test_pop_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no completion want finish before limit");
    $fatal(1, "time limit");
  end
endmodule
